// File: rtl/sequence_unloader.sv
// Parallel-to-chunk serializer: captures a query/database sequence pair and streams both out
// INPUT_WIDTH bits per beat, chunk 0 first, over a valid/ready handshake, then pulses done.
module sequence_unloader #(
    parameter int SEQ_LENGTH   = 32,
    parameter int LETTER_WIDTH = 2,
    parameter int INPUT_WIDTH  = 8,
    localparam int SEQ_W       = SEQ_LENGTH * LETTER_WIDTH,
    localparam int NUM_CHUNKS  = SEQ_W / INPUT_WIDTH,
    localparam int CNT_W       = $clog2(NUM_CHUNKS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [SEQ_W-1:0]       query_seq_in,
    input  logic [SEQ_W-1:0]       database_seq_in,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] query_chunk_out,
    output logic [INPUT_WIDTH-1:0] database_chunk_out,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_last,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [SEQ_W-1:0] query_shadow;
    logic [SEQ_W-1:0] database_shadow;
    logic             capture;

    // Chunk i is the same bit slice the load path writes into its register i.
    logic [INPUT_WIDTH-1:0] query_chunks    [NUM_CHUNKS];
    logic [INPUT_WIDTH-1:0] database_chunks [NUM_CHUNKS];

    for (genvar i = 0; i < NUM_CHUNKS; i++) begin : g_chunks
        assign query_chunks[i]    = query_shadow[i*INPUT_WIDTH +: INPUT_WIDTH];
        assign database_chunks[i] = database_shadow[i*INPUT_WIDTH +: INPUT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            query_shadow    <= '0;
            database_shadow <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (capture) begin
                query_shadow    <= query_seq_in;
                database_shadow <= database_seq_in;
            end
        end
    end

    // Outputs decode only registered state, so out_ready never reaches out_valid combinationally.
    always_comb begin
        state_nxt          = state;
        count_nxt          = count;
        capture            = 1'b0;
        busy               = 1'b0;
        out_valid          = 1'b0;
        query_chunk_out    = '0;
        database_chunk_out = '0;
        out_count          = '0;
        out_last           = 1'b0;
        done               = 1'b0;

        unique case (state)
            IDLE: begin
                if (load) begin
                    capture   = 1'b1;
                    count_nxt = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy               = 1'b1;
                out_valid          = 1'b1;
                query_chunk_out    = query_chunks[count];
                database_chunk_out = database_chunks[count];
                out_count          = count;
                out_last           = (count == LAST_CHUNK);
                if (out_ready) begin
                    if (count == LAST_CHUNK) begin
                        state_nxt = DONE;
                    end else begin
                        count_nxt = count + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                count_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_unloader.sv
// Directed bench for sequence_unloader: expected beats are queued when a load is accepted and
// compared against every valid output cycle; done/busy/valid follow from the queue state.
module tb_sequence_unloader;

    localparam int SEQ_W = 64;
    localparam int IW    = 8;
    localparam int NC    = 8;

    typedef struct packed {
        logic [IW-1:0] q;
        logic [IW-1:0] d;
        logic [2:0]    cnt;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [SEQ_W-1:0] query_seq_in;
    logic [SEQ_W-1:0] database_seq_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [IW-1:0]    query_chunk_out;
    logic [IW-1:0]    database_chunk_out;
    logic [2:0]       out_count;
    logic             out_last;
    logic             done;

    beat_t sb[$];
    bit    done_pend;
    int    n_checks;
    int    n_errors;

    always #5 clk = ~clk;

    sequence_unloader dut (
        .clk                (clk),
        .rst                (rst),
        .load               (load),
        .query_seq_in       (query_seq_in),
        .database_seq_in    (database_seq_in),
        .busy               (busy),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .query_chunk_out    (query_chunk_out),
        .database_chunk_out (database_chunk_out),
        .out_count          (out_count),
        .out_last           (out_last),
        .done               (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [SEQ_W-1:0] qs, input logic [SEQ_W-1:0] ds);
        beat_t b;
        for (int i = 0; i < NC; i++) begin
            b.q    = qs[i*IW +: IW];
            b.d    = ds[i*IW +: IW];
            b.cnt  = 3'(i);
            b.last = (i == NC - 1);
            sb.push_back(b);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, then move past the edge.
    task automatic step();
        bit    done_now;
        bit    idle;
        bit    popped_last;
        beat_t b;
        @(negedge clk);
        done_now    = done_pend;
        idle        = (sb.size() == 0) && !done_now;
        popped_last = 1'b0;
        check("valid", 64'(out_valid), 64'(sb.size() != 0));
        check("busy", 64'(busy), 64'(!idle));
        check("done", 64'(done), 64'(done_now));
        if (sb.size() != 0) begin
            b = sb[0];
            check("query_chunk", 64'(query_chunk_out), 64'(b.q));
            check("database_chunk", 64'(database_chunk_out), 64'(b.d));
            check("count", 64'(out_count), 64'(b.cnt));
            check("last", 64'(out_last), 64'(b.last));
            if (out_ready) begin
                popped_last = b.last;
                void'(sb.pop_front());
            end
        end else begin
            check("idle_zero", 64'({query_chunk_out, database_chunk_out, out_count, out_last}), 64'(0));
        end
        done_pend = popped_last;
        if (rst) begin
            sb.delete();
            done_pend = 1'b0;
        end else if (load && idle) begin
            push_seq(query_seq_in, database_seq_in);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        done_pend       = 1'b0;
        rst             = 1'b1;
        load            = 1'b0;
        out_ready       = 1'b1;
        query_seq_in    = '0;
        database_seq_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle hold after reset.
        repeat (20) step();

        // Round trip with out_ready held high.
        query_seq_in    = 64'hE4E4_E4E4_E4E4_E4E4;
        database_seq_in = 64'h0123_4567_89AB_CDEF;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 3 == 0);
            step();
        end
        out_ready = 1'b1;
        repeat (3) step();
        check("backpressure_drain", 64'(sb.size()), 64'(0));

        // Loads during SEND (beat 3) and during DONE are ignored.
        query_seq_in    = 64'hDEAD_BEEF_CAFE_F00D;
        database_seq_in = 64'h1357_9BDF_0246_8ACE;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            load = (i == 4) || (i == 9);
            if (load) begin
                query_seq_in    = ~query_seq_in;
                database_seq_in = database_seq_in ^ 64'hFFFF_0000_FFFF_0000;
            end
            step();
        end
        load = 1'b0;
        repeat (2) step();

        // Reset after beat 4 is accepted, then a fresh load.
        query_seq_in    = 64'h0F1E_2D3C_4B5A_6978;
        database_seq_in = 64'h8877_6655_4433_2211;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (5) step();
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        query_seq_in    = 64'hA5A5_5A5A_3C3C_C3C3;
        database_seq_in = 64'hFEDC_BA98_7654_3210;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (10) step();

        // Back-to-back: second load in the first cycle with busy low.
        query_seq_in    = 64'h1111_2222_3333_4444;
        database_seq_in = 64'h5555_6666_7777_8888;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (9) step();
        query_seq_in    = 64'h9999_AAAA_BBBB_CCCC;
        database_seq_in = 64'hDDDD_EEEE_FFFF_0000;
        load = 1'b1;
        step();
        load = 1'b0;
        check("b2b_accepted", 64'(sb.size()), 64'(NC));
        repeat (11) step();
        check("final_drain", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
